// File: rtl/multi_interval_timer.sv
// NUM_CH independent down-counting interval timers behind one 16-bit Avalon-MM slave.
// Each channel has a period, one-shot/continuous mode, start/stop, a counter snapshot and an irq.
module multi_interval_timer #(
  parameter int NUM_CH         = 2,
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 49,
  parameter int DEFAULT_RUN    = 1,
  parameter int ADDR_W         = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic [NUM_CH-1:0] irq
);

  localparam int CH_W = ADDR_W - 3;
  localparam logic RUN_INIT = (DEFAULT_RUN != 0);
  localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(DEFAULT_PERIOD);

  typedef enum logic [2:0] {
    REG_STATUS  = 3'd0,
    REG_CONTROL = 3'd1,
    REG_PERIODL = 3'd2,
    REG_PERIODH = 3'd3,
    REG_SNAPL   = 3'd4,
    REG_SNAPH   = 3'd5
  } reg_e;

  logic [CH_W-1:0] ch_sel;
  reg_e            reg_sel;
  logic            bus_wr;
  logic [15:0]     rd_val [NUM_CH];
  logic [15:0]     rd_next;

  assign ch_sel  = address[ADDR_W-1:3];
  assign reg_sel = reg_e'(address[2:0]);
  assign bus_wr  = chipselect & ~write_n;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] snap;
    logic [CNT_W-1:0] period_wr;
    logic [31:0]      period_ext;
    logic [31:0]      snap_ext;
    logic [15:0]      chan_rd;
    logic             to, ito, cont, run;
    logic             tick, wr;

    assign wr         = bus_wr && (ch_sel == CH_W'(i));
    assign tick       = run && (counter == '0);
    assign period_ext = 32'(period);
    assign snap_ext   = 32'(snap);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
      period_wr = period;
      if (reg_sel == REG_PERIODL) period_wr[15:0] = writedata;
      else                        period_wr[CNT_W-1:16] = writedata[CNT_W-17:0];
    end

    // NOTE: state is updated with non-blocking assignments; later bus writes override the count path.
    always_ff @(posedge clk) begin
      if (reset) begin
        counter <= PERIOD_INIT;
        period  <= PERIOD_INIT;
        snap    <= '0;
        to      <= 1'b0;
        ito     <= 1'b0;
        cont    <= RUN_INIT;
        run     <= RUN_INIT;
      end else begin
        if (run) counter <= tick ? period : counter - 1'b1;
        if (tick) begin
          to <= 1'b1;
          if (!cont) run <= 1'b0;
        end
        if (wr) begin
          unique case (reg_sel)
            REG_STATUS:  if (!tick) to <= 1'b0;  // a coincident timeout is never lost
            REG_CONTROL: begin
              ito  <= writedata[0];
              cont <= writedata[1];
              if (writedata[3])      run <= 1'b0;
              else if (writedata[2]) run <= 1'b1;
            end
            REG_PERIODL, REG_PERIODH: begin
              period  <= period_wr;
              counter <= period_wr;
              run     <= 1'b0;
            end
            REG_SNAPL: snap <= counter;
            default: ;
          endcase
        end
      end
    end

    always_comb begin
      chan_rd = '0;
      unique case (reg_sel)
        REG_STATUS:  chan_rd = {14'b0, run, to};
        REG_CONTROL: chan_rd = {14'b0, cont, ito};
        REG_PERIODL: chan_rd = period_ext[15:0];
        REG_PERIODH: chan_rd = period_ext[31:16];
        REG_SNAPL:   chan_rd = snap_ext[15:0];
        REG_SNAPH:   chan_rd = snap_ext[31:16];
        default:     chan_rd = '0;
      endcase
    end

    assign rd_val[i] = chan_rd;
    assign irq[i]    = to & ito;
  end

  // Unpopulated channel indices fall through to zero.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_W'(i)) rd_next = rd_val[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)           readdata <= '0;
    else if (chipselect) readdata <= rd_next;
  end

endmodule

// File: tb/tb_multi_interval_timer.sv
// Directed bench for multi_interval_timer: reads are queued with their expected data and
// a monitor compares readdata one cycle after each read strobe.
module tb_multi_interval_timer;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 32;
  localparam int ADDR_W = 5;  // one spare channel bit so unpopulated channels are addressable

  logic              clk        = 1'b0;
  logic              reset      = 1'b1;
  logic [ADDR_W-1:0] address    = '0;
  logic              chipselect = 1'b0;
  logic              write_n    = 1'b1;
  logic [15:0]       writedata  = '0;
  logic [15:0]       readdata;
  logic [NUM_CH-1:0] irq;

  multi_interval_timer #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_PERIOD(49), .DEFAULT_RUN(1), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  rd_exp_t mon_e;
  int      n_cmp    = 0;
  int      n_err    = 0;
  logic    rd_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a read strobe seen at a rising edge has its data valid from that edge on.
  always @(posedge clk) rd_valid <= chipselect & write_n & ~reset;

  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check("read_without_expectation", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check(mon_e.name, 32'(readdata), 32'(mon_e.exp));
      end
    end
  end

  // Bus tasks start at a falling edge; the access is taken at the next rising edge.
  task automatic wr(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [15:0] e, input string name);
    rd_exp_t it;
    it.name = name;
    it.exp  = e;
    exp_q.push_back(it);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_readdata", 32'(readdata), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    reset = 1'b0;                                   // edge E1 is the first out of reset

    // Reset values and the free-running OS tick on channel 0
    rd(5'd0, 16'h0002, "ch0_status_reset");         // E1
    rd(5'd1, 16'h0002, "ch0_control_reset");        // E2
    rd(5'd2, 16'h0031, "ch0_periodl_reset");        // E3
    rd(5'd3, 16'h0000, "ch0_periodh_reset");        // E4
    idle(45);
    rd(5'd0, 16'h0002, "ch0_status_before_to");     // E50
    rd(5'd0, 16'h0003, "ch0_status_first_to");      // E51
    check("irq_masked", 32'(irq), 32'h0);
    wr(5'd0, 16'h0000);                             // E52 clear TO
    idle(47);
    rd(5'd0, 16'h0002, "ch0_status_before_to2");    // E100
    rd(5'd0, 16'h0003, "ch0_status_second_to");     // E101
    wr(5'd1, 16'h0003);                             // E102 ITO=1, CONT=1
    check("irq0_enabled", 32'(irq), 32'h1);
    rd(5'd1, 16'h0003, "ch0_control_ito");          // E103

    // STATUS clear coinciding with a timeout keeps TO
    wr(5'd0, 16'h0000);                             // E104
    idle(45);
    wr(5'd0, 16'h0000);                             // E150 = timeout edge
    rd(5'd0, 16'h0003, "ch0_to_survives_clear");    // E151
    check("irq0_after_coincident_clear", 32'(irq), 32'h1);
    wr(5'd0, 16'h0000);                             // E152
    rd(5'd0, 16'h0002, "ch0_to_cleared");           // E153
    check("irq0_cleared", 32'(irq), 32'h0);

    // START+STOP together: STOP wins and the counter holds
    wr(5'd1, 16'h000C);                             // E154, counter 46 -> 45 then holds
    wr(5'd4, 16'h0000);                             // E155 snapshot
    rd(5'd4, 16'd45, "ch0_snap_after_stop");        // E156
    idle(20);
    wr(5'd4, 16'h0000);                             // E177
    rd(5'd4, 16'd45, "ch0_snap_20_later");          // E178
    rd(5'd0, 16'h0000, "ch0_status_stopped");       // E179

    // Channel 1 one-shot, period 9, interrupt enabled
    wr(5'd10, 16'd9);                               // E180
    wr(5'd11, 16'd0);                               // E181
    wr(5'd8, 16'h0000);                             // E182 clear TO from reset-period run
    wr(5'd9, 16'h0005);                             // E183 START, ITO, one-shot
    idle(9);
    check("irq1_before_timeout", 32'(irq), 32'h0);
    idle(1);
    check("irq1_at_timeout", 32'(irq), 32'h2);
    rd(5'd8, 16'h0001, "ch1_status_oneshot");
    wr(5'd12, 16'h0000);
    rd(5'd12, 16'd9, "ch1_snapl_reloaded");
    rd(5'd13, 16'd0, "ch1_snaph_reloaded");
    wr(5'd8, 16'h0000);
    idle(30);
    rd(5'd8, 16'h0000, "ch1_no_retrigger");
    check("irq1_no_retrigger", 32'(irq), 32'h0);
    wr(5'd12, 16'h0000);
    rd(5'd12, 16'd9, "ch1_counter_held");

    // Carry across the 16-bit halves with period 0x0001_0000
    wr(5'd10, 16'h0000);
    wr(5'd11, 16'h0001);
    wr(5'd12, 16'h0000);
    rd(5'd12, 16'h0000, "ch1_snapl_loaded");
    rd(5'd13, 16'h0001, "ch1_snaph_loaded");
    rd(5'd11, 16'h0001, "ch1_periodh");
    wr(5'd9, 16'h0004);                             // START, one-shot, no irq
    idle(2);
    wr(5'd12, 16'h0000);
    rd(5'd12, 16'hFFFE, "ch1_snapl_carry");
    rd(5'd13, 16'h0000, "ch1_snaph_carry");

    // Unpopulated channels read zero and ignore writes; readdata holds while idle
    rd(5'd2, 16'h0031, "ch0_periodl_before_invalid");
    rd(5'd18, 16'h0000, "ch2_invalid_read");
    rd(5'd26, 16'h0000, "ch3_invalid_read");
    wr(5'd18, 16'h1234);
    wr(5'd17, 16'h0004);
    rd(5'd0, 16'h0000, "ch0_status_unaffected");
    rd(5'd2, 16'h0031, "ch0_period_unaffected");
    idle(3);
    check("readdata_hold", 32'(readdata), 32'h31);

    // One-cycle reset in the middle of counting
    wr(5'd1, 16'h0007);
    idle(5);
    rd(5'd12, 16'hFFFE, "ch1_snapl_before_reset");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("readdata_after_reset", 32'(readdata), 32'h0);
    check("irq_after_reset", 32'(irq), 32'h0);
    wr(5'd4, 16'h0000);
    rd(5'd4, 16'd49, "ch0_counter_after_reset");
    rd(5'd0, 16'h0002, "ch0_status_after_reset");
    rd(5'd1, 16'h0002, "ch0_control_after_reset");
    rd(5'd10, 16'h0031, "ch1_periodl_after_reset");
    rd(5'd11, 16'h0000, "ch1_periodh_after_reset");
    rd(5'd12, 16'h0000, "ch1_snap_after_reset");

    idle(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
